// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the MainMemory read port and
// buffers fetched {pc, instruction} pairs in a 2-entry queue toward decode.
// Redirect flushes the queue and reloads the PC; halt stops new fetches
// while the queue keeps draining.
module instr_fetch_stage #(
   parameter int unsigned       ADDR_W   = 17,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              memread,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_out,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [DATA_W-1:0] id_instr,
   output logic [ADDR_W-1:0] id_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              misalign_err,
   output logic [31:0]       fetch_count
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] q_pc    [2];
   logic [DATA_W-1:0] q_instr [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        count;
   logic              pop;
   logic              fetch_en;

   // Handshake, fetch enable and queue-head presentation.
   always_comb begin
      id_valid = (count != 2'd0);
      pop      = id_valid & id_ready;
      // Held in reset, no fetch is issued even though the queue is empty.
      fetch_en = rst_n & !halt & !redirect_valid & ((count < 2'd2) | pop);
      memread  = fetch_en;
      address  = fetch_en ? pc : '0;
      id_instr = id_valid ? q_instr[rd_ptr] : '0;
      id_pc    = id_valid ? q_pc[rd_ptr]    : '0;
   end

   // PC, queue storage/pointers, misalign pulse and fetch counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         q_pc[0]      <= '0;
         q_pc[1]      <= '0;
         q_instr[0]   <= '0;
         q_instr[1]   <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         count        <= 2'd0;
         misalign_err <= 1'b0;
         fetch_count  <= '0;
      end else begin
         misalign_err <= redirect_valid & (|redirect_pc[1:0]);
         if (redirect_valid) begin
            pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            if (fetch_en) begin
               q_pc[wr_ptr]    <= pc;
               q_instr[wr_ptr] <= data_out;
               wr_ptr          <= ~wr_ptr;
               pc              <= pc + ADDR_W'(4);
               if (fetch_count != '1)
                  fetch_count <= fetch_count + 32'd1;
            end
            if (pop)
               rd_ptr <= ~rd_ptr;
            case ({fetch_en, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_instr_fetch_stage;

   localparam int unsigned ADDR_W = 17;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              memread;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_out;
   logic              id_valid;
   logic              id_ready;
   logic [DATA_W-1:0] id_instr;
   logic [ADDR_W-1:0] id_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic              misalign_err;
   logic [31:0]       fetch_count;

   int tests  = 0;
   int failed = 0;

   instr_fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(17'h0)) dut (
      .clk(clk), .rst_n(rst_n), .memread(memread), .address(address),
      .data_out(data_out), .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_pc(id_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halt(halt), .misalign_err(misalign_err),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Program image: two fixed words at 0 and 4, a hash of the address elsewhere.
   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      if (a == 17'h0) return 32'h8D10_0200;
      if (a == 17'h4) return 32'h8D30_0300;
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   always_comb data_out = mem_word(address);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       instr;
   } ent_t;

   ent_t              mq[$];
   logic [ADDR_W-1:0] m_pc  = '0;
   logic [31:0]       m_cnt = '0;
   logic              m_mis = 1'b0;

   always @(negedge rst_n) begin
      mq.delete();
      m_pc  = '0;
      m_cnt = '0;
      m_mis = 1'b0;
   end

   function automatic logic m_fetch();
      logic pop;
      pop = (mq.size() != 0) && id_ready;
      return rst_n && !halt && !redirect_valid && (mq.size() < 2 || pop);
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         logic pop, fe;
         pop = (mq.size() != 0) && id_ready;
         fe  = m_fetch();
         m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & ~17'h3;
         end else begin
            if (pop) void'(mq.pop_front());
            if (fe) begin
               mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
               m_pc = m_pc + 17'd4;
               if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic fe;
      fe = m_fetch();
      chk("memread", 32'(memread), 32'(fe));
      chk("address", 32'(address), fe ? 32'(m_pc) : 32'h0);
      chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
      chk("id_pc", 32'(id_pc), (mq.size() != 0) ? 32'(mq[0].pc) : 32'h0);
      chk("id_instr", id_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
      chk("fetch_count", fetch_count, m_cnt);
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; id_ready = 1'b1; halt = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      mid();
      chk("rst id_valid", 32'(id_valid), 32'h0);
      chk("rst id_instr", id_instr, 32'h0);
      chk("rst id_pc", 32'(id_pc), 32'h0);
      chk("rst memread", 32'(memread), 32'h0);
      chk("rst misalign", 32'(misalign_err), 32'h0);
      chk("rst fetch_count", fetch_count, 32'h0);

      // Reset release with id_ready=1: one instruction per cycle.
      cyc(); rst_n = 1'b1;
      mid(); chk("t1 memread", 32'(memread), 32'h1); chk("t1 addr0", 32'(address), 32'h0);
      cyc(); mid();
      chk("t1 valid", 32'(id_valid), 32'h1); chk("t1 pc0", 32'(id_pc), 32'h0);
      chk("t1 instr0", id_instr, 32'h8D10_0200); chk("t1 cnt1", fetch_count, 32'd1);
      cyc(); mid();
      chk("t1 pc4", 32'(id_pc), 32'h4); chk("t1 instr4", id_instr, 32'h8D30_0300);
      chk("t1 cnt2", fetch_count, 32'd2);

      // id_ready=0 from reset: queue fills after two fetches.
      cyc(); rst_n = 1'b0; id_ready = 1'b0;
      #1; chk("t2 async valid", 32'(id_valid), 32'h0); chk("t2 async cnt", fetch_count, 32'h0);
      cyc(); rst_n = 1'b1;
      mid(); chk("t2 addr0", 32'(address), 32'h0);
      cyc(); mid(); chk("t2 addr4", 32'(address), 32'h4);
      cyc(); mid(); chk("t2 full memread", 32'(memread), 32'h0); chk("t2 cnt", fetch_count, 32'd2);
      cyc(); mid(); chk("t2 hold memread", 32'(memread), 32'h0);
      cyc(); id_ready = 1'b1;
      mid(); chk("t2 pop pc0", 32'(id_pc), 32'h0); chk("t2 resume memread", 32'(memread), 32'h1);
      chk("t2 resume addr8", 32'(address), 32'h8);
      cyc(); mid(); chk("t2 pop pc4", 32'(id_pc), 32'h4); chk("t2 addrC", 32'(address), 32'hC);

      // Redirect while the queue is full.
      cyc(); id_ready = 1'b0;
      mid(); chk("t3 full", 32'(memread), 32'h0);
      cyc(); redirect_valid = 1'b1; redirect_pc = 17'h30;
      mid(); chk("t3 redir memread", 32'(memread), 32'h0);
      cyc(); redirect_valid = 1'b0; id_ready = 1'b1;
      mid(); chk("t3 flushed", 32'(id_valid), 32'h0); chk("t3 addr30", 32'(address), 32'h30);
      chk("t3 no misalign", 32'(misalign_err), 32'h0);
      cyc(); mid(); chk("t3 head30", 32'(id_pc), 32'h30); chk("t3 addr34", 32'(address), 32'h34);

      // Misaligned redirect.
      cyc(); redirect_valid = 1'b1; redirect_pc = 17'h32;
      mid(); chk("t4 redir memread", 32'(memread), 32'h0);
      cyc(); redirect_valid = 1'b0;
      mid(); chk("t4 misalign hi", 32'(misalign_err), 32'h1); chk("t4 addr30", 32'(address), 32'h30);
      cyc(); mid(); chk("t4 misalign lo", 32'(misalign_err), 32'h0); chk("t4 head30", 32'(id_pc), 32'h30);

      // Halt with two entries queued: drain, no fetch, resume at held pc.
      cyc(); id_ready = 1'b0;
      cyc(); mid(); chk("t5 full", 32'(memread), 32'h0);
      cyc(); halt = 1'b1; id_ready = 1'b1;
      mid(); chk("t5 drain34", 32'(id_pc), 32'h34); chk("t5 memread0a", 32'(memread), 32'h0);
      cyc(); mid(); chk("t5 drain38", 32'(id_pc), 32'h38); chk("t5 memread0b", 32'(memread), 32'h0);
      cyc(); mid(); chk("t5 empty", 32'(id_valid), 32'h0); chk("t5 memread0c", 32'(memread), 32'h0);
      cyc(); halt = 1'b0;
      mid(); chk("t5 resume", 32'(memread), 32'h1); chk("t5 addr3C", 32'(address), 32'h3C);

      // PC wrap at the top of the address space.
      cyc(); redirect_valid = 1'b1; redirect_pc = 17'h1FFFC;
      cyc(); redirect_valid = 1'b0;
      mid(); chk("t6 addr1FFFC", 32'(address), 32'h1FFFC);
      cyc(); mid(); chk("t6 wrap addr0", 32'(address), 32'h0); chk("t6 head1FFFC", 32'(id_pc), 32'h1FFFC);
      cyc(); mid(); chk("t6 head0", 32'(id_pc), 32'h0); chk("t6 instr0", id_instr, 32'h8D10_0200);

      // Reset mid-stream.
      cyc(); #2 rst_n = 1'b0;
      #1; chk("t7 async valid", 32'(id_valid), 32'h0); chk("t7 async memread", 32'(memread), 32'h0);
      chk("t7 async cnt", fetch_count, 32'h0);
      cyc(); rst_n = 1'b1;
      mid(); chk("t7 restart", 32'(memread), 32'h1); chk("t7 addr0", 32'(address), 32'h0);

      // Randomized traffic; the per-cycle compare does the checking.
      for (int i = 0; i < 3000; i++) begin
         cyc();
         id_ready       = ($urandom_range(0, 9) < 7);
         halt           = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? 17'h1FFFC : ADDR_W'($urandom);
         rst_n          = ($urandom_range(0, 199) != 0);
      end
      cyc();
      rst_n = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
      cyc(); mid();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS datapath, directly upstream of MainMemory.
- Owns the program counter and drives MainMemory's read port (memread, address); the memory returns data_out combinationally in the same cycle.
- Captures {pc, instruction} into a 2-entry fetch queue and presents it to decode over a valid/ready handshake.
- Handles stall (backpressure), halt, and branch/jump redirect with flush.

Parameters:
- ADDR_W, 17, width of MainMemory byte address and of the PC.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memread  out  1  read strobe to MainMemory; 1 only in a fetch cycle.
- address  out  ADDR_W  byte address to MainMemory; equals the current PC.
- data_out  in  DATA_W  instruction word returned by MainMemory, same cycle.
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  DATA_W  instruction at the queue head.
- id_pc  out  ADDR_W  PC of the instruction at the queue head.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  redirect target.
- halt  in  1  level; suppresses new fetches.
- misalign_err  out  1  registered one-cycle pulse when redirect_pc[1:0] != 0.
- fetch_count  out  32  count of instructions pushed into the queue; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; queue empty (count=0, rd/wr pointers 0).
  - id_valid=0, id_instr=0, id_pc=0.
  - misalign_err=0, fetch_count=0, memread=0.
- Queue: 2 entries of {pc, instr}, with a count register (0..2). id_valid = (count != 0). id_instr and id_pc come combinationally from the head entry; they are 0 when the queue is empty.
- pop = id_valid & id_ready.
- fetch_en = !halt & !redirect_valid & (count < 2 | pop).
  - A full queue with a pop in the same cycle still fetches.
- memread = fetch_en; address = pc whenever memread = 1, otherwise 0.
- Fetch cycle (fetch_en=1):
  - Push {pc, data_out} at the clock edge.
  - pc <= pc + 4, modulo 2^ADDR_W, so 2^ADDR_W-4 wraps to 0.
  - fetch_count++ unless saturated.
- Latency: an instruction fetched in cycle N appears at the head in cycle N+1 if the queue was empty. Throughput is 1 instruction/cycle while id_ready=1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop on empty: impossible, since pop requires id_valid. Push when full without a pop: impossible, since fetch_en=0.
- Redirect (redirect_valid=1) has the highest priority:
  - Queue is flushed: count=0, pointers reset, any pop that cycle is discarded.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - memread=0 that cycle.
  - misalign_err <= |redirect_pc[1:0] for one cycle.
  - Fetch at the target starts the next cycle; its instruction is at the head 2 cycles after the redirect cycle.
- Halt: no fetches and pc holds. The queue keeps draining to decode. Releasing halt resumes fetch at the held pc. Redirect during halt still flushes and loads pc.
- Reset mid-operation: everything returns to reset values immediately (async). The first fetch occurs in the first cycle after rst_n deasserts.
- No memwrite is driven by this block; the memory write port belongs to the load/store stage.

Test Plan:
- Reset release, id_ready=1, program image loaded:
  - cycle 0 shows memread=1, address=0.
  - next cycle shows id_valid=1, id_pc=0, id_instr=0x8D100200.
  - following cycle shows id_pc=4, id_instr=0x8D300300.
  - fetch_count increments by 1 per cycle.
- id_ready=0 from reset:
  - two fetches (addresses 0, 4), then memread=0 and pc holds at 8; fetch_count=2.
  - raise id_ready: pops of pc 0 and pc 4, fetch resumes at 8 in the same cycle as the first pop.
- Redirect while the queue is full: redirect_valid=1, redirect_pc=0x30.
  - next cycle id_valid=0; fetch at 0x30.
  - id_pc=0x30 one cycle after that; old entries are never presented.
- Redirect with redirect_pc=0x32: misalign_err pulses 1 for exactly one cycle; fetch proceeds at 0x30.
- halt=1 with 2 entries queued and id_ready=1: both drain, memread stays 0, pc unchanged; after halt=0, fetch resumes at the held pc.
- Wrap: redirect to 0x1FFFC, then fetches at 0x1FFFC then 0x00000. Separately, assert rst_n=0 mid-stream: id_valid drops immediately, and fetch restarts at RESET_PC.
